// File: rtl/banked_mem_pkg.sv
// Shared constants and types for the four-bank interleaved memory responder.
package banked_mem_pkg;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int NUM_BANKS    = 4;
    localparam int BANK_SEL_LSB = 1;
    localparam int BANK_SEL_W   = 2;
    localparam int RD_LATENCY   = 2;
    localparam int ROW_W        = DEF_ADDR_W - 3;
    localparam int CNT_W        = 4;

    typedef logic [BANK_SEL_W-1:0] bank_idx_t;
endpackage

// File: rtl/banked_mem_responder_if.sv
// Request/response bundle between the cache controller and banked_mem_responder.
// Optional busy vector is present when BANKED_MEM_BUSY_OUT_EN is defined.
interface banked_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Handshake: a request (Rd or Wr) is taken on a rising edge when stall is low;
    // while stall is high the requester holds Addr/DataIn/Rd/Wr unchanged.
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] DataIn;
    logic              Rd;
    logic              Wr;
    logic [DATA_W-1:0] DataOut;
    logic              DataValid;
    logic              stall;
    logic              err;
`ifdef BANKED_MEM_BUSY_OUT_EN
    logic [3:0]        busy;
`endif

    modport master (
        output Addr, DataIn, Rd, Wr,
        input  DataOut, DataValid, stall, err
`ifdef BANKED_MEM_BUSY_OUT_EN
        , input busy
`endif
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr,
        output DataOut, DataValid, stall, err
`ifdef BANKED_MEM_BUSY_OUT_EN
        , output busy
`endif
    );
endinterface

// File: rtl/banked_mem_responder_mem_bank.sv
// One memory bank: storage array, busy countdown and the first read pipeline stage.
module mem_bank
    import banked_mem_pkg::*;
#(
    parameter int ROW_BITS    = 13,
    parameter int DATA_W      = 16,
    parameter int BANK_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                acc,
    input  logic                we,
    input  logic [ROW_BITS-1:0] row,
    input  logic [DATA_W-1:0]   wdata,
    output logic                busy,
    output logic                s1_valid,
    output logic [DATA_W-1:0]   s1_data
);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(BANK_CYCLES - 1);

    logic [DATA_W-1:0] mem [0:(1<<ROW_BITS)-1];
    logic [CNT_W-1:0]  cnt;

    assign busy = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            if (acc)
                cnt <= LOAD;
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
            s1_valid <= acc & ~we;
            if (acc && !we)
                s1_data <= mem[row];
        end
    end

    // Storage survives reset; acc is already masked by rst upstream.
    always_ff @(posedge clk) begin
        if (acc && we)
            mem[row] <= wdata;
    end
endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank interleaved memory responder with fixed 2-cycle read latency.
// Define BANKED_MEM_BUSY_OUT_EN to expose the per-bank busy vector.
module banked_mem_responder
    import banked_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BANK_CYCLES = 4
) (
    input logic                  clk,
    input logic                  rst,
    banked_mem_responder_if.slave bus
);
    localparam int ROW_BITS = ADDR_W - 3;

    logic                 req;
    logic                 illegal;
    logic                 legal_req;
    logic                 accept;
    bank_idx_t            bank;
    logic [ROW_BITS-1:0]  row;
    logic [NUM_BANKS-1:0] busy_vec;
    logic [NUM_BANKS-1:0] s1_valid;
    logic [DATA_W-1:0]    s1_data [NUM_BANKS];
    logic [DATA_W-1:0]    s2_next;
    logic [DATA_W-1:0]    s2_data;
    logic                 s2_valid;
    logic                 err_q;

    assign req       = bus.Rd | bus.Wr;
    assign illegal   = (bus.Rd & bus.Wr) | (req & bus.Addr[0]);
    assign bank      = bus.Addr[BANK_SEL_LSB +: BANK_SEL_W];
    assign row       = bus.Addr[ADDR_W-1:3];
    assign legal_req = req & ~illegal & ~rst;
    assign accept    = legal_req & ~busy_vec[bank];
    assign bus.stall = legal_req & busy_vec[bank];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .ROW_BITS   (ROW_BITS),
            .DATA_W     (DATA_W),
            .BANK_CYCLES(BANK_CYCLES)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .acc     (accept && (bank == bank_idx_t'(b))),
            .we      (bus.Wr),
            .row     (row),
            .wdata   (bus.DataIn),
            .busy    (busy_vec[b]),
            .s1_valid(s1_valid[b]),
            .s1_data (s1_data[b])
        );
    end

    // At most one bank holds a valid stage-1 result in any cycle.
    always_comb begin
        s2_next = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (s1_valid[b])
                s2_next = s1_data[b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            err_q    <= 1'b0;
        end else begin
            s2_valid <= |s1_valid;
            s2_data  <= s2_next;
            err_q    <= illegal;
        end
    end

    assign bus.DataValid = s2_valid;
    assign bus.DataOut   = s2_valid ? s2_data : '0;
    assign bus.err       = err_q;

`ifdef BANKED_MEM_BUSY_OUT_EN
    assign bus.busy = rst ? 4'b0000 : busy_vec;
`endif
endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed bench for banked_mem_responder: burst, bank conflict, RAW, illegal, reset.
module tb_banked_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_drv = 1'b1;
    int   total = 0;
    int   bad = 0;

    banked_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    banked_mem_responder dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at the falling edge, settle, leave sampling to the caller.
    task automatic cyc(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        rst        = rst_drv;
        bus.Rd     = rd;
        bus.Wr     = wr;
        bus.Addr   = a;
        bus.DataIn = d;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] d);
        check_eq({tag, "_valid"}, 32'(bus.DataValid), 32'(v));
        check_eq({tag, "_data"}, 32'(bus.DataOut), 32'(d));
    endtask

    initial begin
        bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = '0; bus.DataIn = '0;

        // reset state
        rst_drv = 1'b1;
        repeat (3) idle();
        check_out("rst", 1'b0, 16'h0000);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        check_eq("rst_stall", 32'(bus.stall), 32'd0);
`ifdef BANKED_MEM_BUSY_OUT_EN
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
`endif
        rst_drv = 1'b0;
        idle();

        // burst writes then burst reads, four different banks
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 16'h1200 + 16'(2*i), 16'h00A0 + 16'(i));
            check_eq("burst_wr_stall", 32'(bus.stall), 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                cyc(1'b1, 1'b0, 16'h1200 + 16'(2*i), 16'h0000);
                check_eq("burst_rd_stall", 32'(bus.stall), 32'd0);
            end else begin
                idle();
            end
            if (i >= 2) check_out("burst_rd", 1'b1, 16'h00A0 + 16'(i-2));
            else        check_out("burst_pre", 1'b0, 16'h0000);
        end
        idle();
        check_out("burst_end", 1'b0, 16'h0000);

        // preload bank 0 words, respecting bank busy time
        cyc(1'b0, 1'b1, 16'h0010, 16'h1111); repeat (3) idle();
        cyc(1'b0, 1'b1, 16'h0018, 16'h2222); repeat (3) idle();
        cyc(1'b0, 1'b1, 16'h0000, 16'h0BEE); repeat (3) idle();
        cyc(1'b0, 1'b1, 16'h0040, 16'h4040); repeat (4) idle();

        // bank conflict on bank 0
        cyc(1'b1, 1'b0, 16'h0010, 16'h0000);
        check_eq("conf_t_stall", 32'(bus.stall), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b1, 1'b0, 16'h0018, 16'h0000);
            check_eq("conf_stall", 32'(bus.stall), 32'd1);
            if (k == 2) check_out("conf_first", 1'b1, 16'h1111);
            else        check_out("conf_wait", 1'b0, 16'h0000);
        end
        cyc(1'b1, 1'b0, 16'h0018, 16'h0000);
        check_eq("conf_acc_stall", 32'(bus.stall), 32'd0);
        idle();
        check_out("conf_t5", 1'b0, 16'h0000);
        idle();
        check_out("conf_second", 1'b1, 16'h2222);

        // read-after-write, same word in bank 1
        cyc(1'b0, 1'b1, 16'h0302, 16'h5555);
        check_eq("raw_wr_stall", 32'(bus.stall), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b1, 1'b0, 16'h0302, 16'h0000);
            check_eq("raw_stall", 32'(bus.stall), 32'd1);
        end
        cyc(1'b1, 1'b0, 16'h0302, 16'h0000);
        check_eq("raw_acc_stall", 32'(bus.stall), 32'd0);
        idle();
        check_out("raw_t5", 1'b0, 16'h0000);
        idle();
        check_out("raw_data", 1'b1, 16'h5555);

        // illegal requests
        cyc(1'b1, 1'b1, 16'h0000, 16'hDEAD);
        check_eq("ill_rw_stall", 32'(bus.stall), 32'd0);
        idle();
        check_eq("ill_rw_err", 32'(bus.err), 32'd1);
        check_out("ill_rw", 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0001, 16'h0000);
        check_eq("ill_odd_stall", 32'(bus.stall), 32'd0);
        idle();
        check_eq("ill_odd_err", 32'(bus.err), 32'd1);
        check_out("ill_odd", 1'b0, 16'h0000);
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
        check_eq("ill_after_stall", 32'(bus.stall), 32'd0);
        check_eq("ill_after_err", 32'(bus.err), 32'd0);
        idle();
        idle();
        check_out("ill_unchanged", 1'b1, 16'h0BEE);
        repeat (2) idle();

        // reset in the middle of a read
        cyc(1'b1, 1'b0, 16'h0040, 16'h0000);
        check_eq("rstrd_stall", 32'(bus.stall), 32'd0);
        rst_drv = 1'b1;
        cyc(1'b1, 1'b0, 16'h0040, 16'h0000);
        check_eq("rstrd_rst_stall", 32'(bus.stall), 32'd0);
        check_out("rstrd_t1", 1'b0, 16'h0000);
        rst_drv = 1'b0;
        cyc(1'b1, 1'b0, 16'h0040, 16'h0000);
        check_eq("rstrd_acc_stall", 32'(bus.stall), 32'd0);
        check_out("rstrd_t2", 1'b0, 16'h0000);
        idle();
        check_out("rstrd_t3", 1'b0, 16'h0000);
        idle();
        check_out("rstrd_data", 1'b1, 16'h4040);

`ifdef BANKED_MEM_BUSY_OUT_EN
        repeat (4) idle();
        cyc(1'b0, 1'b1, 16'h0004, 16'h7777);
        check_eq("busy_t0", 32'(bus.busy), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            idle();
            check_eq("busy_on", 32'(bus.busy), 32'h4);
        end
        idle();
        check_eq("busy_off", 32'(bus.busy), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
